// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack and the control unit that drives it.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stack_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  // Stack command encodings
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_PUSH  = 2'b01,
    OP_POP   = 2'b10,
    OP_REPL2 = 2'b11
  } op_e;

  // Error codes reported when the error port option is built in
  localparam logic [1:0] ERR_NONE        = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW    = 2'b01;
  localparam logic [1:0] ERR_UNDERFLOW   = 2'b10;
  localparam logic [1:0] ERR_REPL2_SHORT = 2'b11;

endpackage

// File: rtl/stack_regfile.sv
// Slot storage for the operand stack: one synchronous write port, two async reads.
// Latency: write visible on the read ports after the clock edge; reads are combinational.
// Backpressure: none; the owner decides when to write.
//
// Ports:
//   clk              clock
//   we/waddr/wdata   write port (physical address 0..DEPTH-1)
//   raddr_a/rdata_a  read port A (async)
//   raddr_b/rdata_b  read port B (async)
// Contents are deliberately not reset.
module stack_regfile #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr_a,
  output logic [DATA_W-1:0]        rdata_a,
  input  logic [$clog2(DEPTH)-1:0] raddr_b,
  output logic [DATA_W-1:0]        rdata_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/operand_stack.sv
// Operand stack: PUSH / POP / REPL2 on a DEPTH-entry LIFO with TOS and NOS taps.
// Latency: every command completes on the next rising edge; outputs come from registered state.
// Backpressure: none; illegal commands (overflow/underflow/short REPL2) are dropped.
//
// Ports:
//   clk, reset (async, active-low)
//   op [1:0], din           command and data for PUSH / REPL2
//   tos, nos                top and next-on-stack (0 when absent)
//   index, empty, full      occupancy
// Build option OPERAND_STACK_ERR_EN adds: err (sticky), err_code [1:0], clr_err.
module operand_stack
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             op,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      tos,
  output logic [DATA_W-1:0]      nos,
  output logic [$clog2(DEPTH):0] index,
  output logic                   empty,
  output logic                   full
`ifdef OPERAND_STACK_ERR_EN
  ,
  output logic                   err,
  output logic [1:0]             err_code,
  input  logic                   clr_err
`endif
);

  localparam int IDX_W  = $clog2(DEPTH) + 1;
  localparam int ADDR_W = $clog2(DEPTH);

  logic [IDX_W-1:0]  index_q;
  logic              is_push, is_pop, is_repl;
  logic              push_ok, pop_ok, repl_ok;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [ADDR_W-1:0] tos_addr, nos_addr;
  logic [DATA_W-1:0] tos_raw, nos_raw;

  // Occupancy decode
  assign empty = (index_q == '0);
  assign full  = (index_q == IDX_W'(DEPTH));
  assign index = index_q;

  // Command legality
  assign is_push = (op == OP_PUSH);
  assign is_pop  = (op == OP_POP);
  assign is_repl = (op == OP_REPL2);
  assign push_ok = is_push && !full;
  assign pop_ok  = is_pop && !empty;
  assign repl_ok = is_repl && (index_q >= IDX_W'(2));

  // Slot n lives at physical address n-1. PUSH targets slot index+1 (phys index),
  // REPL2 overwrites slot index-1 (phys index-2). Upper bits dropped by truncation;
  // out-of-range values only occur when the result is gated off.
  assign rf_we    = push_ok || repl_ok;
  assign rf_waddr = push_ok ? ADDR_W'(index_q) : ADDR_W'(index_q - IDX_W'(2));
  assign tos_addr = ADDR_W'(index_q - IDX_W'(1));
  assign nos_addr = ADDR_W'(index_q - IDX_W'(2));

  stack_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (din),
    .raddr_a (tos_addr),
    .rdata_a (tos_raw),
    .raddr_b (nos_addr),
    .rdata_b (nos_raw)
  );

  // Slots are never reset, so mask the taps whenever index excludes them
  assign tos = (index_q >= IDX_W'(1)) ? tos_raw : '0;
  assign nos = (index_q >= IDX_W'(2)) ? nos_raw : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index_q <= '0;
    end else if (push_ok) begin
      index_q <= index_q + IDX_W'(1);
    end else if (pop_ok || repl_ok) begin
      index_q <= index_q - IDX_W'(1);
    end
  end

`ifdef OPERAND_STACK_ERR_EN
  logic       err_new;
  logic [1:0] err_new_code;

  always_comb begin
    err_new      = 1'b0;
    err_new_code = ERR_NONE;
    if (is_push && full) begin
      err_new      = 1'b1;
      err_new_code = ERR_OVERFLOW;
    end else if (is_pop && empty) begin
      err_new      = 1'b1;
      err_new_code = ERR_UNDERFLOW;
    end else if (is_repl && !repl_ok) begin
      err_new      = 1'b1;
      err_new_code = ERR_REPL2_SHORT;
    end
  end

  // A new error wins over clr_err. While err is held the first code is kept,
  // unless clr_err releases it in the same cycle, in which case the new code loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (err_new) begin
      err <= 1'b1;
      if (!err || clr_err) begin
        err_code <= err_new_code;
      end
    end else if (clr_err) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end
  end
`endif

endmodule

// File: tb/tb_operand_stack.sv
`timescale 1ns/1ps
module tb_operand_stack;
  import stack_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic                   clk;
  logic                   reset;
  logic [1:0]             op;
  logic [DATA_W-1:0]      din;
  logic [DATA_W-1:0]      tos, nos;
  logic [$clog2(DEPTH):0] index;
  logic                   empty, full;
`ifdef OPERAND_STACK_ERR_EN
  logic                   err;
  logic [1:0]             err_code;
  logic                   clr_err;
`endif

  operand_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .din      (din),
    .tos      (tos),
    .nos      (nos),
    .index    (index),
    .empty    (empty),
    .full     (full)
`ifdef OPERAND_STACK_ERR_EN
    ,
    .err      (err),
    .err_code (err_code),
    .clr_err  (clr_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int tos, nos, idx, empty, full, err, code;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a plain queue of values plus sticky error state
  int model_st[$];
  int model_err  = 0;
  int model_code = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model_view(input int c);
    exp_t e;
    int n;
    n       = model_st.size();
    e.cyc   = c;
    e.idx   = n;
    e.tos   = (n >= 1) ? model_st[n-1] : 0;
    e.nos   = (n >= 2) ? model_st[n-2] : 0;
    e.empty = (n == 0);
    e.full  = (n == DEPTH);
    e.err   = model_err;
    e.code  = model_code;
    return e;
  endfunction

  // Monitor: compares each expectation on the negedge of the cycle it belongs to
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("tos",   int'(tos),   e.tos);
        check("nos",   int'(nos),   e.nos);
        check("index", int'(index), e.idx);
        check("empty", int'(empty), e.empty);
        check("full",  int'(full),  e.full);
`ifdef OPERAND_STACK_ERR_EN
        check("err",      int'(err),      e.err);
        check("err_code", int'(err_code), e.code);
`endif
      end
    end
  end

  // Called at posedge+1: drive one command, record its expected effect, advance a cycle
  task automatic issue(input logic [1:0] o, input int d, input bit clr);
    int n;
    int ill;
    op  = o;
    din = DATA_W'(d);
`ifdef OPERAND_STACK_ERR_EN
    clr_err = clr;
`endif
    n   = model_st.size();
    ill = 0;
    case (o)
      OP_PUSH:  if (n < DEPTH) model_st.push_back(d & 8'hff); else ill = 1;
      OP_POP:   if (n > 0) void'(model_st.pop_back()); else ill = 2;
      OP_REPL2: if (n >= 2) begin
                  void'(model_st.pop_back());
                  void'(model_st.pop_back());
                  model_st.push_back(d & 8'hff);
                end else ill = 3;
      default: ;
    endcase
`ifdef OPERAND_STACK_ERR_EN
    if (ill != 0) begin
      if (model_err == 0 || clr) model_code = ill;
      model_err = 1;
    end else if (clr) begin
      model_err  = 0;
      model_code = 0;
    end
`else
    if (clr && ill != 0) model_err = 0;
`endif
    exp_q.push_back(model_view(cyc + 1));
    @(posedge clk);
    #1;
    op  = OP_NOP;
    din = DATA_W'($urandom);
`ifdef OPERAND_STACK_ERR_EN
    clr_err = 1'b0;
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_index"}, int'(index), 0);
    check({tag, "_empty"}, int'(empty), 1);
    check({tag, "_full"},  int'(full),  0);
    check({tag, "_tos"},   int'(tos),   0);
    check({tag, "_nos"},   int'(nos),   0);
`ifdef OPERAND_STACK_ERR_EN
    check({tag, "_err"},   int'(err),   0);
`endif
  endtask

  // Mid-cycle reset for 30 ns with a command optionally on the bus; checked before the next edge
  task automatic mid_reset(input logic [1:0] o, input int d);
    @(negedge clk);
    #1;
    op  = o;
    din = DATA_W'(d);
    #2 reset = 1'b0;
    #1 check_reset_state("rst_async");
    #29 reset = 1'b1;
    op = OP_NOP;
    model_st.delete();
    model_err  = 0;
    model_code = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    op    = OP_NOP;
    din   = '0;
`ifdef OPERAND_STACK_ERR_EN
    clr_err = 1'b0;
`endif
    #2 check_reset_state("rst_init");
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    // Single push, then the PUSH/PUSH/REPL2/POP sequence
    issue(OP_PUSH, 5, 0);
    issue(OP_POP, 0, 0);
    issue(OP_PUSH, 5, 0);
    issue(OP_PUSH, 7, 0);
    issue(OP_REPL2, 12, 0);
    issue(OP_POP, 0, 0);

    // Fill to full, then overflow attempt
    for (int i = 1; i <= DEPTH; i++) issue(OP_PUSH, i, 0);
    issue(OP_PUSH, 99, 0);
    issue(OP_NOP, 0, 0);

    // Underflow and short REPL2 from empty
    mid_reset(OP_NOP, 0);
    issue(OP_POP, 0, 0);
    issue(OP_PUSH, 3, 0);
    issue(OP_REPL2, 8, 0);
    issue(OP_POP, 0, 0);
    // clr_err together with a new underflow: the error must stay set
    issue(OP_POP, 0, 1);
    issue(OP_NOP, 0, 1);
    issue(OP_NOP, 0, 0);

    // Reset asserted while a PUSH is on the bus
    issue(OP_PUSH, 21, 0);
    issue(OP_PUSH, 22, 0);
    issue(OP_PUSH, 23, 0);
    mid_reset(OP_PUSH, 55);
    issue(OP_PUSH, 4, 0);

    // Randomized back-to-back traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      int r;
      logic [1:0] o;
      r = $urandom_range(0, 9);
      if (r == 0)      o = OP_NOP;
      else if (r <= 4) o = OP_PUSH;
      else if (r <= 7) o = OP_POP;
      else             o = OP_REPL2;
      if ((i % 200) == 199) mid_reset(o, $urandom_range(0, 255));
      else issue(o, $urandom_range(0, 255), ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    #1;
    check("queue_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_stack.md
OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 Parameter DATA_W, 8, width of one stack entry.
REQ-002 Parameter DEPTH, 16, maximum number of entries; power of two, at least 4.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 op  input  2  command: 00 NOP, 01 PUSH, 10 POP, 11 REPL2 (pop two entries, push din).
REQ-006 din  input  DATA_W  data for PUSH/REPL2 (PUSH_I immediate, RAM word, temp1 or ALU result).
REQ-007 tos  output  DATA_W  top-of-stack; the POP data source for the RAM write path.
REQ-008 nos  output  DATA_W  next-on-stack; second ALU operand.
REQ-009 index  output  $clog2(DEPTH)+1  number of valid entries (0 = empty).
REQ-010 empty  output  1  high when index == 0.
REQ-011 full  output  1  high when index == DEPTH.

Function
REQ-012 Storage SHALL be slots 1..DEPTH; the top entry SHALL be slot[index].
REQ-013 PUSH with index < DEPTH SHALL write din to slot[index+1] and increment index.
REQ-014 POP with index > 0 SHALL decrement index; slot contents SHALL be unchanged.
REQ-015 REPL2 with index >= 2 SHALL write din to slot[index-1] and decrement index by 1.
REQ-016 Illegal commands SHALL leave index and all slots unchanged: PUSH when full, POP when empty, REPL2 when index < 2.
REQ-017 All commands SHALL complete in one cycle; tos, nos, index, empty and full SHALL reflect the command one clock edge after it is applied.
REQ-018 tos SHALL be slot[index] when index >= 1, else 0; nos SHALL be slot[index-1] when index >= 2, else 0; both purely from registered state.
REQ-019 empty and full SHALL be decoded combinationally from index and SHALL never be high together.
REQ-020 Back-to-back commands on consecutive cycles SHALL be accepted with no bubbles.
REQ-021 din SHALL be sampled only in the cycle in which a PUSH or REPL2 is applied.

Reset
REQ-022 Asserting reset SHALL force index to 0 immediately (empty=1, full=0, tos=0, nos=0), including mid-command.
REQ-023 Slot contents SHALL NOT be reset; they are unobservable while index excludes them.
REQ-024 The first command SHALL take effect on the first rising edge after reset deasserts.

Configuration
REQ-025 Macro OPERAND_STACK_ERR_EN defined: add ports err (output, 1, sticky), err_code (output, 2: 01 overflow, 10 underflow, 11 REPL2 short), and clr_err (input, 1).
REQ-026 With OPERAND_STACK_ERR_EN, an illegal command SHALL set err and load err_code on the same edge; later errors SHALL NOT overwrite err_code while err=1; clr_err SHALL clear both, and a simultaneous new error SHALL take priority over clr_err; reset SHALL clear both.
REQ-027 Without OPERAND_STACK_ERR_EN the three ports SHALL be absent and illegal commands SHALL be silently ignored per REQ-016.

Structure
REQ-028 Package stack_pkg SHALL hold DATA_W/DEPTH defaults, the op encodings (OP_NOP, OP_PUSH, OP_POP, OP_REPL2) and the err_code values, shared with the control unit.
REQ-029 One sub-module, stack_regfile (one write port, two asynchronous read ports, no reset), SHALL hold the slots; pointer and flag logic SHALL stay in operand_stack.

Verification
REQ-030 Reset, then PUSH din=5 -> next cycle tos=5, index=1, empty=0.
REQ-031 PUSH 5, PUSH 7 -> tos=7, nos=5, index=2; REPL2 din=12 -> tos=12, nos=0, index=1; POP -> index=0, empty=1, tos=0.
REQ-032 Sixteen PUSHes of 1..16 -> full=1, tos=16; a 17th PUSH of 99 -> tos=16, index=16 unchanged; with OPERAND_STACK_ERR_EN, err=1 and err_code=01.
REQ-033 From empty: POP, then PUSH 3 and REPL2 with din=8 -> index stays 0, then 1, then 1 with tos=3; with OPERAND_STACK_ERR_EN, err_code=10 is held through the later REPL2 error.
REQ-034 Three PUSHes, then reset asserted for 30 ns mid-cycle during a PUSH -> empty=1 and index=0 immediately (before the next edge); a PUSH 4 after release -> tos=4, index=1.
REQ-035 With OPERAND_STACK_ERR_EN, clr_err pulsed in the same cycle as a POP-when-empty -> err remains 1 with err_code=10.
